// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, DDRAM geometry, timing defaults and address-counter stepping
package lcd_pkg;
  typedef enum logic [1:0] {ST_PWRUP, ST_READY, ST_BUSY} lcd_state_t;
  localparam int PWRUP_CYCLES_DEF = 750_000;
  localparam int CMD_CYCLES_DEF = 1_850;
  localparam int CLR_CYCLES_DEF = 76_500;
  localparam int MIN_EN_CYCLES_DEF = 12;
  localparam logic [7:0] OP_SETA = 8'h80;
  localparam logic [7:0] OP_DISP_MASK = 8'hF8;
  localparam logic [7:0] OP_DISP = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_HOME_MASK = 8'hFE;
  localparam logic [7:0] OP_HOME = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam logic [7:0] SPACE = 8'h20;
  // Out-of-line addresses snap to the start of the other line; otherwise step with line wrap.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (ac[5:0] > 6'h27) return ac[6] ? LINE1_BASE : LINE2_BASE;
    if (inc) return ac == LINE1_LAST ? LINE2_BASE : ac == LINE2_LAST ? LINE1_BASE : ac + 7'd1;
    return ac == LINE1_BASE ? LINE2_LAST : ac == LINE2_BASE ? LINE1_LAST : ac - 7'd1;
  endfunction
endpackage

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: aligned 2-flop bus synchronizer, EN falling-edge strobe and EN width check
module lcd_strobe_sync #(
  parameter int MIN_EN_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       strobe,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s,
  output logic       width_ok
);
  localparam logic [7:0] MIN_W = 8'(MIN_EN_CYCLES);
  logic [10:0] s1, s2;
  logic en_d;
  logic [7:0] wcnt;
  // Whole bus goes through one synchronizer so rs/rw/data stay aligned with EN; width saturates.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      en_d <= 1'b0;
      wcnt <= '0;
    end else begin
      s1 <= {en, rs, rw, data};
      s2 <= s1;
      en_d <= s2[10];
      wcnt <= s2[10] ? (wcnt == 8'hFF ? wcnt : wcnt + 8'd1) : 8'd0;
    end
  assign strobe = en_d & ~s2[10];
  assign rs_s = s2[9];
  assign rw_s = s2[8];
  assign data_s = s2[7:0];
  assign width_ok = wcnt >= MIN_W;
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style display-side bus responder with DDRAM mirror and violation checks
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEF,
  parameter int CMD_CYCLES = CMD_CYCLES_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int MIN_EN_CYCLES = MIN_EN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       ready,
  output logic       display_on,
  output logic [6:0] ac,
  output logic       cmd_valid,
  output logic       char_valid,
  output logic [7:0] last_byte,
  output logic       viol,
  output logic [7:0] viol_cnt
);
  localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_CYCLES - 1);
  localparam logic [19:0] CMD_LD = 20'(CMD_CYCLES);
  localparam logic [19:0] CLR_LD = 20'(CLR_CYCLES);
  lcd_state_t state, state_n;
  logic [19:0] pcnt, bcnt, bcnt_n;
  logic [7:0] ddram [32];
  logic id;
  logic strobe, rs_s, rw_s, width_ok;
  logic [7:0] data_s;
  logic accept, is_cmd, is_chr, is_seta, is_disp, is_entry, is_home, is_clr, wr_hit;
  logic [4:0] wr_idx;
  lcd_strobe_sync #(.MIN_EN_CYCLES(MIN_EN_CYCLES)) u_sync (
    .clk(clk), .rst(rst), .en(lcd_en), .rs(lcd_rs), .rw(lcd_rw), .data(lcd_data),
    .strobe(strobe), .rs_s(rs_s), .rw_s(rw_s), .data_s(data_s), .width_ok(width_ok)
  );
  // Accept decision, instruction decode and next state / busy counter.
  always_comb begin
    accept = strobe && state == ST_READY && !rw_s && width_ok;
    is_cmd = accept && !rs_s;
    is_chr = accept && rs_s;
    is_seta = (data_s & OP_SETA) != 8'h00;
    is_disp = (data_s & OP_DISP_MASK) == OP_DISP;
    is_entry = (data_s & OP_ENTRY_MASK) == OP_ENTRY;
    is_home = (data_s & OP_HOME_MASK) == OP_HOME;
    is_clr = data_s == OP_CLEAR;
    wr_hit = is_chr && (ac[6:4] == 3'b000 || ac[6:4] == 3'b100);
    wr_idx = {ac[6], ac[3:0]};
    bcnt_n = accept ? (is_cmd && (is_home || is_clr) ? CLR_LD : CMD_LD) : bcnt != 20'd0 ? bcnt - 20'd1 : 20'd0;
    state_n = state == ST_PWRUP ? (pcnt == PWRUP_LAST ? ST_READY : ST_PWRUP)
            : accept ? ST_BUSY
            : state == ST_BUSY && bcnt == 20'd1 ? ST_READY : state;
  end
  // State, power-up counter and busy counter.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_PWRUP;
      pcnt <= '0;
      bcnt <= '0;
    end else begin
      state <= state_n;
      pcnt <= state == ST_PWRUP ? pcnt + 20'd1 : pcnt;
      bcnt <= bcnt_n;
    end
  // Display registers, DDRAM mirror, event pulses and violation count.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 32; i++) ddram[i] <= SPACE;
      ac <= '0;
      id <= 1'b1;
      display_on <= 1'b0;
      cmd_valid <= 1'b0;
      char_valid <= 1'b0;
      viol <= 1'b0;
      last_byte <= '0;
      viol_cnt <= '0;
    end else begin
      if (is_cmd && is_clr) for (int i = 0; i < 32; i++) ddram[i] <= SPACE;
      else if (wr_hit) ddram[wr_idx] <= data_s;
      ac <= is_cmd ? (is_seta ? data_s[6:0] : is_home || is_clr ? LINE1_BASE : ac)
          : is_chr ? ac_step(ac, id) : ac;
      id <= is_cmd && is_clr ? 1'b1 : is_cmd && is_entry ? data_s[1] : id;
      display_on <= is_cmd && is_disp ? data_s[2] : display_on;
      cmd_valid <= is_cmd;
      char_valid <= is_chr;
      viol <= strobe && !accept;
      last_byte <= accept ? data_s : last_byte;
      viol_cnt <= strobe && !accept && viol_cnt != 8'hFF ? viol_cnt + 8'd1 : viol_cnt;
    end
  assign ready = state != ST_PWRUP;
  assign busy = bcnt != 20'd0;
  assign rd_char = ddram[rd_idx];
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed bus strobes with a pulse scoreboard and state spot checks
module tb_lcd_bus_responder;
  localparam logic [2:0] K_CMD = 3'b001;
  localparam logic [2:0] K_CHR = 3'b010;
  localparam logic [2:0] K_VIOL = 3'b100;
  typedef struct packed {logic [2:0] kind; logic [7:0] b;} exp_t;
  logic clk = 1'b0, rst = 1'b1, lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char, last_byte, viol_cnt;
  logic busy, ready, display_on, cmd_valid, char_valid, viol;
  logic [6:0] ac;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic [7:0] last_ok = 8'h00;
  lcd_bus_responder #(.PWRUP_CYCLES(4000), .CMD_CYCLES(1850), .CLR_CYCLES(3000), .MIN_EN_CYCLES(12)) dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .rd_idx(rd_idx), .rd_char(rd_char), .busy(busy), .ready(ready), .display_on(display_on),
    .ac(ac), .cmd_valid(cmd_valid), .char_valid(char_valid), .last_byte(last_byte),
    .viol(viol), .viol_cnt(viol_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [4:0] i, input logic [7:0] exp);
    rd_idx = i;
    #1 chk($sformatf("rd_char[%0d]", i), 32'(rd_char), 32'(exp));
  endtask
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int width, input logic ok);
    exp_t e;
    if (ok) last_ok = d;
    e.kind = ok ? (rs ? K_CHR : K_CMD) : K_VIOL;
    e.b = last_ok;
    q.push_back(e);
    lcd_rs = rs;
    lcd_rw = rw;
    lcd_data = d;
    repeat (2) @(negedge clk);
    lcd_en = 1'b1;
    repeat (width) @(negedge clk);
    lcd_en = 1'b0;
    repeat (5) @(negedge clk);
    lcd_rw = 1'b0;
  endtask
  task automatic wr(input logic rs, input logic [7:0] d, input int gap);
    strobe(rs, 1'b0, d, 100, 1'b1);
    repeat (gap) @(negedge clk);
  endtask
  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clk)
    if (!rst && (cmd_valid || char_valid || viol)) begin : mon
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pulse unexpected kind %b byte %0h", {viol, char_valid, cmd_valid}, last_byte);
      end else begin
        e = q.pop_front();
        if ({viol, char_valid, cmd_valid} !== e.kind || last_byte !== e.b) begin
          errors++;
          $display("FAIL pulse got kind %b byte %0h want kind %b byte %0h",
                   {viol, char_valid, cmd_valid}, last_byte, e.kind, e.b);
        end
      end
    end
  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] init_seq [8];
    int n;
    init_seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready", ready, 0);
    chk("reset busy", busy, 0);
    chk("reset ac", ac, 0);
    chk("reset viol_cnt", viol_cnt, 0);
    chk("reset display_on", display_on, 0);
    rd(5'd0, 8'h20);
    repeat (990) @(negedge clk);
    strobe(1'b0, 1'b0, 8'h38, 100, 1'b0);
    chk("early viol_cnt", viol_cnt, 1);
    n = 0;
    while (!ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("ready after powerup", ready, 1);
    foreach (init_seq[i]) wr(1'b0, init_seq[i], init_seq[i] == 8'h01 ? 3200 : 2000);
    chk("init display_on", display_on, 1);
    chk("init ac", ac, 0);
    chk("init viol_cnt", viol_cnt, 1);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h20);
    wr(1'b0, 8'h01, 3200);
    wr(1'b1, 8'h45, 2000);
    wr(1'b1, 8'h4E, 2000);
    wr(1'b1, 8'h54, 2000);
    rd(5'd0, 8'h45);
    rd(5'd1, 8'h4E);
    rd(5'd2, 8'h54);
    chk("ac after ENT", ac, 3);
    wr(1'b0, 8'hC0, 2000);
    wr(1'b1, 8'h31, 500);
    rd(5'd16, 8'h31);
    chk("ac line2", ac, 7'h41);
    strobe(1'b1, 1'b0, 8'h5A, 100, 1'b0);
    rd(5'd17, 8'h20);
    chk("busy viol_cnt", viol_cnt, 2);
    chk("busy viol ac", ac, 7'h41);
    repeat (1400) @(negedge clk);
    strobe(1'b1, 1'b0, 8'h5A, 12, 1'b1);
    repeat (2000) @(negedge clk);
    rd(5'd17, 8'h5A);
    chk("ac after Z", ac, 7'h42);
    wr(1'b0, 8'hA7, 2000);
    chk("ac set 27", ac, 7'h27);
    wr(1'b1, 8'h58, 2000);
    chk("ac wrap 40", ac, 7'h40);
    rd(5'd7, 8'h20);
    rd(5'd16, 8'h31);
    strobe(1'b1, 1'b1, 8'h51, 100, 1'b0);
    repeat (2000) @(negedge clk);
    strobe(1'b1, 1'b0, 8'h51, 5, 1'b0);
    repeat (2000) @(negedge clk);
    chk("rw/short viol_cnt", viol_cnt, 4);
    chk("rw/short ac", ac, 7'h40);
    rd(5'd16, 8'h31);
    wr(1'b0, 8'h04, 2000);
    wr(1'b0, 8'h80, 2000);
    wr(1'b1, 8'h41, 2000);
    rd(5'd0, 8'h41);
    chk("ac dec wrap 67", ac, 7'h67);
    strobe(1'b0, 1'b0, 8'h01, 100, 1'b1);
    repeat (100) @(negedge clk);
    chk("busy after clear", busy, 1);
    chk("ac after clear", ac, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst ready", ready, 0);
    chk("rst viol_cnt", viol_cnt, 0);
    chk("rst display_on", display_on, 0);
    rd(5'd17, 8'h20);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
